// File: rtl/hawk_cdm_sched.sv
`default_nettype none
// hawk_cdm_sched -- grants the shared HAWK compress/decompress/migrate engine to one operation at a time
// Rev 1.0 -- initial release
module hawk_cdm_sched #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        comp_req_i,
  input  logic        decomp_req_i,
  input  logic        migrate_req_i,
  output logic        comp_ack_o,
  output logic        decomp_ack_o,
  output logic        migrate_ack_o,
  output logic        err_o,
  output logic [13:0] comp_size_o,
  output logic        incompressible_o,
  output logic        comp_start_o,
  output logic        decomp_start_o,
  output logic        migrate_start_o,
  input  logic        comp_done_i,
  input  logic        decomp_done_i,
  input  logic        migrate_done_i,
  input  logic [13:0] comp_size_i,
  input  logic        incompressible_i,
  output logic        busy_o,
  output logic [1:0]  active_op_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_NONE    = 2'd0;
  localparam logic [1:0] OP_COMP    = 2'd1;
  localparam logic [1:0] OP_DECOMP  = 2'd2;
  localparam logic [1:0] OP_MIGRATE = 2'd3;

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);

  logic [1:0]      state;
  logic [1:0]      op;
  logic [WD_W-1:0] wdog;
  logic [SC_W-1:0] starve;
  logic            rr_ptr;       // 0: compress next, 1: migrate next
  logic            err;
  logic [13:0]     comp_size;
  logic            incompressible;

  logic       other_pending;
  logic       starved;
  logic       rr_pick_migrate;
  logic [1:0] grant;
  logic       done_match;

  always_comb begin
    other_pending   = comp_req_i | migrate_req_i;
    starved         = (starve == SC_MAX) && other_pending;
    rr_pick_migrate = migrate_req_i && (!comp_req_i || rr_ptr);
    grant           = OP_NONE;
    if (decomp_req_i && !starved) begin
      grant = OP_DECOMP;
    end else if (other_pending) begin
      grant = rr_pick_migrate ? OP_MIGRATE : OP_COMP;
    end
    case (op)
      OP_COMP:    done_match = comp_done_i;
      OP_DECOMP:  done_match = decomp_done_i;
      OP_MIGRATE: done_match = migrate_done_i;
      default:    done_match = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      op             <= OP_NONE;
      wdog           <= '0;
      starve         <= '0;
      rr_ptr         <= 1'b0;
      err            <= 1'b0;
      comp_size      <= '0;
      incompressible <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != OP_NONE) begin
            state <= ST_RUN;
            op    <= grant;
            wdog  <= '0;
            if (grant == OP_DECOMP) begin
              if (other_pending && (starve != SC_MAX)) starve <= starve + SC_W'(1);
            end else begin
              starve <= '0;
              rr_ptr <= (grant == OP_COMP);
            end
          end
        end
        ST_RUN: begin
          // A done on the final watchdog cycle still counts as success.
          if (done_match) begin
            err   <= 1'b0;
            state <= ST_DONE;
            if (op == OP_COMP) begin
              comp_size      <= comp_size_i;
              incompressible <= incompressible_i;
            end
          end else if (wdog == WD_LAST) begin
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          op    <= OP_NONE;
        end
        default: begin
          state <= ST_IDLE;
          op    <= OP_NONE;
        end
      endcase
    end
  end

  assign comp_start_o     = (state == ST_RUN)  && (op == OP_COMP);
  assign decomp_start_o   = (state == ST_RUN)  && (op == OP_DECOMP);
  assign migrate_start_o  = (state == ST_RUN)  && (op == OP_MIGRATE);
  assign comp_ack_o       = (state == ST_DONE) && (op == OP_COMP);
  assign decomp_ack_o     = (state == ST_DONE) && (op == OP_DECOMP);
  assign migrate_ack_o    = (state == ST_DONE) && (op == OP_MIGRATE);
  assign err_o            = (state == ST_DONE) && err;
  assign comp_size_o      = comp_size;
  assign incompressible_o = incompressible;
  assign busy_o           = (state != ST_IDLE);
  assign active_op_o      = op;

endmodule
`default_nettype wire

// File: tb/tb_hawk_cdm_sched.sv
`default_nettype none
// tb_hawk_cdm_sched -- directed plus randomized stimulus against a transaction-level reference model
// Rev 1.0 -- initial release
module tb_hawk_cdm_sched;
  localparam int T  = 16;
  localparam int SL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        comp_req, decomp_req, migrate_req;
  logic        comp_ack, decomp_ack, migrate_ack, err;
  logic [13:0] comp_size_out;
  logic        incompressible_out;
  logic        comp_start, decomp_start, migrate_start;
  logic        comp_done, decomp_done, migrate_done;
  logic [13:0] comp_size_in;
  logic        incompressible_in;
  logic        busy;
  logic [1:0]  active_op;

  hawk_cdm_sched #(.TIMEOUT_CYCLES(T), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk), .rst_i(rst),
    .comp_req_i(comp_req), .decomp_req_i(decomp_req), .migrate_req_i(migrate_req),
    .comp_ack_o(comp_ack), .decomp_ack_o(decomp_ack), .migrate_ack_o(migrate_ack),
    .err_o(err), .comp_size_o(comp_size_out), .incompressible_o(incompressible_out),
    .comp_start_o(comp_start), .decomp_start_o(decomp_start), .migrate_start_o(migrate_start),
    .comp_done_i(comp_done), .decomp_done_i(decomp_done), .migrate_done_i(migrate_done),
    .comp_size_i(comp_size_in), .incompressible_i(incompressible_in),
    .busy_o(busy), .active_op_o(active_op)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
  endtask

  // Reference model: operation in flight, its age, and arbitration bookkeeping (ops: 1 comp, 2 decomp, 3 migrate).
  int m_op = 0, m_age = 0, m_delay = 0, m_starve = 0, m_size = 0;
  bit m_run = 0, m_ack = 0, m_err = 0, m_ptr = 0, m_inc = 0, m_after_rst = 0;

  // Requester/engine agents and their knobs.
  bit req[4], drop[4], keep[4], dn[4];
  int p[4];
  int dmode = 2, size_fix = -1;
  bit stray = 0;

  // Observation of the DUT.
  int obs[$];
  logic [2:0] prev_st = 3'b0;
  bit seen_start = 0, rst_seen = 1;
  int low_run = 0, run_len = 0, ack_cnt = 0, err_ack_cnt = 0;

  function automatic int oh(input int op);
    return (op == 0) ? 0 : (1 << (op - 1));
  endfunction

  function automatic int pick();
    bit others;
    others = req[1] | req[3];
    if (req[2] && !(m_starve == SL && others)) return 2;
    if (req[1] && req[3]) return m_ptr ? 3 : 1;
    if (req[1]) return 1;
    if (req[3]) return 3;
    return 0;
  endfunction

  task automatic drive(input bit r);
    rst = r;
    for (int i = 1; i <= 3; i++) begin
      if (drop[i] && !keep[i]) req[i] = 1'b0;
      else if (!req[i] && $urandom_range(99) < p[i]) req[i] = 1'b1;
      drop[i] = 1'b0;
      if (m_run && m_op == i) dn[i] = (m_age == m_delay);
      else dn[i] = stray && ($urandom_range(3) == 0);
    end
    comp_req = req[1]; decomp_req = req[2]; migrate_req = req[3];
    comp_done = dn[1]; decomp_done = dn[2]; migrate_done = dn[3];
    comp_size_in = (size_fix >= 0) ? 14'(size_fix) : 14'($urandom_range(16383));
    incompressible_in = 1'($urandom_range(1));
  endtask

  task automatic model_step();
    int g;
    if (rst) begin
      m_op = 0; m_run = 0; m_ack = 0; m_err = 0; m_ptr = 0; m_starve = 0;
      m_size = 0; m_inc = 0; m_after_rst = 1; rst_seen = 1;
    end else begin
      m_after_rst = 0;
      if (m_ack) begin
        drop[m_op] = 1; m_ack = 0; m_op = 0;
      end else if (m_run) begin
        if (dn[m_op]) begin
          m_run = 0; m_ack = 1; m_err = 0;
          if (m_op == 1) begin m_size = int'(comp_size_in); m_inc = incompressible_in; end
        end else if (m_age == T - 1) begin
          m_run = 0; m_ack = 1; m_err = 1;
        end else begin
          m_age++;
        end
      end else begin
        g = pick();
        if (g != 0) begin
          m_run = 1; m_op = g; m_age = 0;
          m_delay = (dmode < 0) ? int'($urandom_range(20)) : dmode;
          if (g == 2) begin
            if ((req[1] | req[3]) && m_starve < SL) m_starve++;
          end else begin
            m_starve = 0; m_ptr = (g == 1);
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("start", int'({migrate_start, decomp_start, comp_start}), m_run ? oh(m_op) : 0);
    check("ack", int'({migrate_ack, decomp_ack, comp_ack}), m_ack ? oh(m_op) : 0);
    check("err", int'(err), int'(m_ack && m_err));
    check("busy", int'(busy), int'(m_run || m_ack));
    check("active_op", int'(active_op), m_op);
    if ((m_ack && m_op == 1) || m_after_rst) begin
      check("comp_size", int'(comp_size_out), m_size);
      check("incompressible", int'(incompressible_out), int'(m_inc));
    end
  endtask

  task automatic track();
    logic [2:0] st, ak;
    st = {migrate_start, decomp_start, comp_start};
    ak = {migrate_ack, decomp_ack, comp_ack};
    if (st != 3'b0 && prev_st == 3'b0) begin
      if (seen_start && !rst_seen) check("start_gap", int'(low_run >= 2), 1);
      obs.push_back(st[0] ? 1 : (st[1] ? 2 : 3));
      seen_start = 1; rst_seen = 0; run_len = 0; low_run = 0;
    end
    if (st != 3'b0) run_len++;
    else low_run++;
    if (ak != 3'b0) begin
      ack_cnt++;
      if (err) begin
        err_ack_cnt++;
        check("timeout_len", run_len, T);
      end
    end
    prev_st = st;
  endtask

  task automatic begin_cycle(input bit r);
    @(negedge clk);
    drive(r);
    #1;
    check_outputs();
    track();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_step();
  endtask

  task automatic run_cycle(input bit r);
    begin_cycle(r);
    end_cycle();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin
      req[i] = 0; p[i] = 0; keep[i] = 0; drop[i] = 0;
    end
    run_cycle(1'b1);
    run_cycle(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    comp_req = 0; decomp_req = 0; migrate_req = 0;
    comp_done = 0; decomp_done = 0; migrate_done = 0;
    comp_size_in = '0; incompressible_in = 0;
    for (int i = 0; i < 4; i++) begin req[i] = 0; p[i] = 0; keep[i] = 0; drop[i] = 0; dn[i] = 0; end
    @(posedge clk);
    model_step();

    // Single compress: request at 10, done with size 37 at 15.
    do_reset();
    dmode = 4; size_fix = 37;
    for (int k = 0; k < 20; k++) begin
      p[1] = (k == 10) ? 100 : 0;
      begin_cycle(1'b0);
      if (k >= 11 && k <= 15) check("tp_comp_start", int'(comp_start), 1);
      if (k == 16) begin
        check("tp_comp_ack", int'(comp_ack), 1);
        check("tp_comp_size", int'(comp_size_out), 37);
        check("tp_comp_err", int'(err), 0);
      end
      if (k == 17) check("tp_busy_low", int'(busy), 0);
      end_cycle();
    end
    size_fix = -1;

    // Simultaneous requests.
    do_reset();
    dmode = 2; obs.delete();
    for (int k = 0; k < 30; k++) begin
      for (int i = 1; i <= 3; i++) p[i] = (k == 1) ? 100 : 0;
      run_cycle(1'b0);
    end
    check("simul_count", obs.size(), 3);
    if (obs.size() >= 3) begin
      check("simul_1st", obs[0], 2);
      check("simul_2nd", obs[1], 1);
      check("simul_3rd", obs[2], 3);
    end

    // Starvation guard: decompress held continuously, migrate always waiting.
    do_reset();
    dmode = 1; obs.delete();
    keep[2] = 1; p[2] = 100; p[3] = 100;
    for (int k = 0; k < 300 && obs.size() < 10; k++) run_cycle(1'b0);
    check("starve_count", int'(obs.size() >= 10), 1);
    if (obs.size() >= 10) begin
      for (int i = 0; i < 8; i++) check("starve_decomp", obs[i], 2);
      check("starve_9th", obs[8], 3);
      check("starve_resume", obs[9], 2);
    end

    // Timeout on migrate, then a normal compress.
    do_reset();
    dmode = 99; ack_cnt = 0; err_ack_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      p[3] = (k == 1) ? 100 : 0;
      run_cycle(1'b0);
    end
    check("to_err_acks", err_ack_cnt, 1);
    dmode = 3; ack_cnt = 0; err_ack_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      p[1] = (k == 0) ? 100 : 0;
      run_cycle(1'b0);
    end
    check("to_next_acks", ack_cnt, 1);
    check("to_next_err_acks", err_ack_cnt, 0);

    // Stray dones during compress, real done on the last watchdog cycle.
    do_reset();
    dmode = T - 1; stray = 1; ack_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      p[1] = (k == 1) ? 100 : 0;
      begin_cycle(1'b0);
      if (comp_ack) begin
        check("coinc_err", int'(err), 0);
        check("coinc_len", run_len, T);
      end
      end_cycle();
    end
    stray = 0;
    check("coinc_acks", ack_cnt, 1);

    // Reset in the third RUN cycle of a compress.
    do_reset();
    dmode = 99; keep[1] = 1;
    for (int k = 0; k < 10; k++) begin
      p[1] = (k == 0) ? 100 : 0;
      p[3] = (k == 4) ? 100 : 0;
      begin_cycle(k == 3);
      if (k == 3) begin obs.delete(); ack_cnt = 0; end
      if (k == 4) check("rst_outputs", int'({comp_start, decomp_start, migrate_start, comp_ack, decomp_ack,
                                             migrate_ack, err, busy, active_op, comp_size_out, incompressible_out}), 0);
      end_cycle();
    end
    check("rst_no_ack", ack_cnt, 0);
    check("rst_regrant", int'(obs.size() >= 1), 1);
    if (obs.size() >= 1) check("rst_ptr_comp", obs[0], 1);

    // Randomized traffic with occasional resets.
    do_reset();
    stray = 1; dmode = -1;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) begin
        for (int i = 1; i <= 3; i++) begin
          p[i] = int'($urandom_range(40));
          keep[i] = ($urandom_range(3) == 0);
        end
      end
      run_cycle($urandom_range(299) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
`default_nettype wire
